// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: frame field order and FSM encoding.
// The receive states are encoded in frame order so "accepting bytes" is a range test.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        FLD_ADDR,
        FLD_LEN,
        FLD_DATA,
        FLD_CSUM
    } field_e;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        ADDR = 4'd1 + 4'(FLD_ADDR),
        LEN  = 4'd1 + 4'(FLD_LEN),
        DATA = 4'd1 + 4'(FLD_DATA),
        CSUM = 4'd1 + 4'(FLD_CSUM),
        VECT = 4'd5,
        HOLD = 4'd6,
        DONE = 4'd7,
        ERR  = 4'd8
    } state_e;

    // A LEN byte of zero means a full 256-byte image.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface prog_loader_if #(
    parameter int MEM_AW = 8
);
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport slave (
        input  ld_valid, ld_data,
        output ld_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_valid, ld_data,
        input  ld_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader_csum.sv
// 8-bit modulo-256 accumulator for the image checksum.
module prog_loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_add,
    input  logic [7:0] i_data,
    output logic [7:0] o_sum
);
    logic [7:0] r_sum;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sum <= 8'd0;
        else if (i_clr)
            r_sum <= 8'd0;
        else if (i_add)
            r_sum <= r_sum + i_data;
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/prog_loader.sv
// Loads a checksummed byte-stream image into memory, writes the reset vector at 0x00,
// then releases the processor reset after a fixed hold.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int RST_HOLD = 2,
    parameter int MEM_AW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_start,
    prog_loader_if.slave    bus,
    output logic            cpu_rst,
    output logic            done,
    output logic            err
);
    localparam logic [8:0] HOLD_LAST = 9'(RST_HOLD - 1);

    state_e            r_state, w_state;
    logic [7:0]        r_start, w_start;
    logic [8:0]        r_len, w_len;
    logic [8:0]        r_cnt, w_cnt;
    logic              r_mem_we, w_mem_we;
    logic [MEM_AW-1:0] r_mem_addr, w_mem_addr;
    logic [7:0]        r_mem_wdata, w_mem_wdata;
    logic              r_cpu_rst, w_cpu_rst;
    logic              r_done, w_done;
    logic              r_err, w_err;
    logic              w_ready, w_xfer;
    logic              w_csum_clr, w_csum_add;
    logic [7:0]        w_sum;
    logic [7:0]        w_data_addr;

    prog_loader_csum u_csum (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_csum_clr),
        .i_add  (w_csum_add),
        .i_data (bus.ld_data),
        .o_sum  (w_sum)
    );

    assign w_ready     = (r_state >= ADDR) && (r_state <= CSUM);
    assign w_xfer      = bus.ld_valid && w_ready;
    assign w_data_addr = r_start + r_cnt[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_start     <= 8'd0;
            r_len       <= 9'd0;
            r_cnt       <= 9'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_cpu_rst   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_start     <= w_start;
            r_len       <= w_len;
            r_cnt       <= w_cnt;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_cpu_rst   <= w_cpu_rst;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state     = r_state;
        w_start     = r_start;
        w_len       = r_len;
        w_cnt       = r_cnt;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_cpu_rst   = r_cpu_rst;
        w_done      = r_done;
        w_err       = r_err;
        w_csum_clr  = 1'b0;
        w_csum_add  = 1'b0;

        unique case (r_state)
            IDLE, DONE, ERR: if (ld_start) begin
                w_state    = ADDR;
                w_cpu_rst  = 1'b0;
                w_done     = 1'b0;
                w_err      = 1'b0;
                w_cnt      = 9'd0;
                w_csum_clr = 1'b1;
            end
            ADDR: if (w_xfer) begin
                w_start = bus.ld_data;
                w_state = LEN;
            end
            LEN: if (w_xfer) begin
                w_len   = len_to_count(bus.ld_data);
                w_cnt   = 9'd0;
                w_state = DATA;
            end
            DATA: if (w_xfer) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = MEM_AW'(w_data_addr);
                w_mem_wdata = bus.ld_data;
                w_csum_add  = 1'b1;
                w_cnt       = r_cnt + 9'd1;
                if (r_cnt + 9'd1 == r_len)
                    w_state = CSUM;
            end
            CSUM: if (w_xfer) begin
                if (bus.ld_data == w_sum) begin
                    // Reset vector lands last so it wins over any image byte at 0x00.
                    w_state     = VECT;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = '0;
                    w_mem_wdata = r_start;
                end else begin
                    w_state = ERR;
                    w_err   = 1'b1;
                end
            end
            VECT: begin
                w_state = HOLD;
                w_cnt   = 9'd0;
            end
            HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state   = DONE;
                    w_cpu_rst = 1'b1;
                    w_done    = 1'b1;
                end else begin
                    w_cnt = r_cnt + 9'd1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.ld_ready  = w_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign cpu_rst       = r_cpu_rst;
    assign done          = r_done;
    assign err           = r_err;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives frames on the byte stream, captures memory
// writes in a local array and compares against hand-computed values.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst;
    logic ld_start;
    logic cpu_rst, done, err;

    prog_loader_if #(.MEM_AW(8)) bus ();

    prog_loader #(.RST_HOLD(2), .MEM_AW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .bus      (bus),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int n_wr  = 0;
    int n_wr0 = 0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            n_wr <= n_wr + 1;
            if (bus.mem_addr == 8'h00)
                n_wr0 <= n_wr0 + 1;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Starts and ends on a falling edge; gap idles the stream first.
    task automatic send(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        waited = 0;
        while (!bus.ld_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.ld_ready)
            check("ready_timeout", {31'd0, bus.ld_ready}, 32'd1);
        else
            @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst          = 1'b0;
        ld_start     = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;

        // Reset values
        @(negedge clk);
        check("rst_ready",   {31'd0, bus.ld_ready}, 32'd0);
        check("rst_we",      {31'd0, bus.mem_we},   32'd0);
        check("rst_addr",    {24'd0, bus.mem_addr}, 32'd0);
        check("rst_wdata",   {24'd0, bus.mem_wdata}, 32'd0);
        check("rst_cpu_rst", {31'd0, cpu_rst},      32'd0);
        check("rst_done",    {31'd0, done},         32'd0);
        check("rst_err",     {31'd0, err},          32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("idle_ready",       {31'd0, bus.ld_ready}, 32'd0);

        // Basic load with exact release timing
        pulse_start();
        check("basic_ready", {31'd0, bus.ld_ready}, 32'd1);
        send(8'h02, 0);
        send(8'h03, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h66, 0);
        check("vect_we",    {31'd0, bus.mem_we},    32'd1);
        check("vect_addr",  {24'd0, bus.mem_addr},  32'h00);
        check("vect_wdata", {24'd0, bus.mem_wdata}, 32'h02);
        check("vect_cpu",   {31'd0, cpu_rst},       32'd0);
        @(negedge clk);
        check("hold1_we",  {31'd0, bus.mem_we}, 32'd0);
        check("hold1_cpu", {31'd0, cpu_rst},    32'd0);
        @(negedge clk);
        check("hold2_cpu",  {31'd0, cpu_rst}, 32'd0);
        check("hold2_done", {31'd0, done},    32'd0);
        @(negedge clk);
        check("basic_cpu",  {31'd0, cpu_rst}, 32'd1);
        check("basic_done", {31'd0, done},    32'd1);
        check("basic_m02", {24'd0, mem[8'h02]}, 32'h11);
        check("basic_m03", {24'd0, mem[8'h03]}, 32'h22);
        check("basic_m04", {24'd0, mem[8'h04]}, 32'h33);
        check("basic_m00", {24'd0, mem[8'h00]}, 32'h02);
        check("done_ready", {31'd0, bus.ld_ready}, 32'd0);

        // Bad checksum, started from DONE
        pulse_start();
        check("restart_cpu",  {31'd0, cpu_rst}, 32'd0);
        check("restart_done", {31'd0, done},    32'd0);
        send(8'h10, 0);
        send(8'h01, 0);
        send(8'hAA, 0);
        send(8'hAB, 0);
        check("bad_err",  {31'd0, err},        32'd1);
        check("bad_we",   {31'd0, bus.mem_we}, 32'd0);
        check("bad_cpu",  {31'd0, cpu_rst},    32'd0);
        check("bad_done", {31'd0, done},       32'd0);
        repeat (3) @(negedge clk);
        check("bad_cpu_late", {31'd0, cpu_rst}, 32'd0);
        check("bad_m10", {24'd0, mem[8'h10]}, 32'hAA);
        check("bad_m00", {24'd0, mem[8'h00]}, 32'h02);

        // Address wrap-around, started from ERR
        pulse_start();
        check("wrap_err_clr", {31'd0, err}, 32'd0);
        base = n_wr0;
        send(8'hFE, 0);
        send(8'h03, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        send(8'h06, 0);
        wait_done("wrap_done");
        check("wrap_mFE", {24'd0, mem[8'hFE]}, 32'h01);
        check("wrap_mFF", {24'd0, mem[8'hFF]}, 32'h02);
        check("wrap_m00", {24'd0, mem[8'h00]}, 32'hFE);
        check("wrap_wr0_count", n_wr0 - base, 32'd2);

        // LEN = 0 means 256 data bytes
        pulse_start();
        base = n_wr;
        send(8'h00, 0);
        send(8'h00, 0);
        for (int i = 0; i < 256; i++)
            send(8'(i), 0);
        send(8'h80, 0);
        wait_done("len0_done");
        check("len0_writes", n_wr - base, 32'd257);
        check("len0_m7F", {24'd0, mem[8'h7F]}, 32'h7F);
        check("len0_mFF", {24'd0, mem[8'hFF]}, 32'hFF);
        check("len0_m00", {24'd0, mem[8'h00]}, 32'h00);
        check("len0_cpu", {31'd0, cpu_rst},    32'd1);

        // Backpressure gaps and ld_start ignored mid-DATA
        pulse_start();
        send(8'h40, $urandom_range(0, 5));
        send(8'h03, $urandom_range(0, 5));
        send(8'h11, $urandom_range(0, 5));
        pulse_start();
        check("mid_start_ready", {31'd0, bus.ld_ready}, 32'd1);
        check("mid_start_err",   {31'd0, err},          32'd0);
        send(8'h22, $urandom_range(0, 5));
        send(8'h33, $urandom_range(0, 5));
        send(8'h66, $urandom_range(0, 5));
        wait_done("gap_done");
        check("gap_m40", {24'd0, mem[8'h40]}, 32'h11);
        check("gap_m41", {24'd0, mem[8'h41]}, 32'h22);
        check("gap_m42", {24'd0, mem[8'h42]}, 32'h33);
        check("gap_m00", {24'd0, mem[8'h00]}, 32'h40);
        pulse_start();
        check("done_restart_cpu",   {31'd0, cpu_rst},      32'd0);
        check("done_restart_done",  {31'd0, done},         32'd0);
        check("done_restart_ready", {31'd0, bus.ld_ready}, 32'd1);

        // Reset in the middle of DATA
        send(8'h80, 0);
        send(8'h04, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        check("pre_rst_we", {31'd0, bus.mem_we}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, bus.ld_ready},  32'd0);
        check("mid_rst_we",    {31'd0, bus.mem_we},    32'd0);
        check("mid_rst_addr",  {24'd0, bus.mem_addr},  32'd0);
        check("mid_rst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        check("mid_rst_cpu",   {31'd0, cpu_rst},       32'd0);
        check("mid_rst_done",  {31'd0, done},          32'd0);
        check("mid_rst_err",   {31'd0, err},           32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        send(8'h80, 0);
        send(8'h02, 0);
        send(8'h05, 0);
        send(8'h06, 0);
        send(8'h0B, 0);
        wait_done("after_rst_done");
        check("after_rst_m80", {24'd0, mem[8'h80]}, 32'h05);
        check("after_rst_m81", {24'd0, mem[8'h81]}, 32'h06);
        check("after_rst_m00", {24'd0, mem[8'h00]}, 32'h80);
        check("after_rst_cpu", {31'd0, cpu_rst},    32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter: RST_HOLD, 2, cycles cpu_rst stays low after the vector write.
REQ-002 SHALL have parameter: MEM_AW, 8, memory address width (256-byte unified memory).
REQ-003 SHALL have port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ld_start  in  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port: ld_valid  in  1  byte-stream valid.
REQ-007 SHALL have port: ld_data  in  8  byte-stream data.
REQ-008 SHALL have port: ld_ready  out  1  loader accepts a byte; a transfer occurs when ld_valid and ld_ready are both high.
REQ-009 SHALL have port: mem_we  out  1  memory write strobe, one cycle per byte.
REQ-010 SHALL have port: mem_addr  out  8  memory write address.
REQ-011 SHALL have port: mem_wdata  out  8  memory write data.
REQ-012 SHALL have port: cpu_rst  out  1  active-low reset to the processor; low holds the processor.
REQ-013 SHALL have port: done  out  1  level; load succeeded and the processor is released.
REQ-014 SHALL have port: err  out  1  level; checksum mismatch.

Function
REQ-015 SHALL accept the stream frame: START_ADDR, LEN (0 = 256), LEN data bytes, CSUM.
REQ-016 SHALL use FSM states IDLE, ADDR, LEN, DATA, CSUM, VECT, HOLD, DONE, ERR.
REQ-017 SHALL use ld_start to move IDLE, DONE or ERR to ADDR, clear done and err, and drive cpu_rst low in the same edge; SHALL ignore ld_start in all other states.
REQ-018 SHALL drive ld_ready high only in ADDR, LEN, DATA and CSUM; each state advances on one transfer.
REQ-019 SHALL register each DATA byte as a write: mem_we is high the cycle after the transfer, with mem_addr = START_ADDR + index, modulo 256.
REQ-020 SHALL accumulate the checksum as the 8-bit sum, modulo 256, of the data bytes only.
REQ-021 SHALL leave DATA after the LENth byte; a byte counter of 9 bits handles LEN=0 (256 bytes).
REQ-022 SHALL, on a CSUM match, go to VECT and issue one write of mem_addr=0x00, mem_wdata=START_ADDR; this reset vector overrides any data written to 0x00.
REQ-023 SHALL, after VECT, hold cpu_rst low for RST_HOLD cycles in HOLD, then go to DONE with cpu_rst=1 and done=1 on the same edge.
REQ-024 SHALL, on a CSUM mismatch, go to ERR with err=1, cpu_rst=0 and no vector write.
REQ-025 SHALL tolerate ld_valid gaps of any length with no timeout; the state is held.
REQ-026 SHALL keep mem_we low in every cycle not listed above; mem_addr and mem_wdata are don't-care when mem_we=0.

Reset
REQ-027 SHALL, on rst low at any time including mid-load, immediately force: state=IDLE, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=0, done=0, err=0, counters and checksum 0.
REQ-028 SHALL keep cpu_rst low after rst deassertion until a successful load completes.

Structure
REQ-029 SHALL define the FSM state encoding and the frame field order in the shared processor package.
REQ-030 SHALL use one sub-module, prog_loader_csum, an 8-bit accumulator with clear and add enable; everything else is in-line.

Verification
REQ-031 SHALL cover a basic load: frame 02,03,11,22,33,66 -> Mem[02..04]=11,22,33; Mem[00]=02; cpu_rst rises 2 cycles after the vector write; done=1.
REQ-032 SHALL cover a bad checksum: frame 10,01,AA,AB -> Mem[10]=AA; err=1; cpu_rst stays 0; Mem[00] unchanged.
REQ-033 SHALL cover wrap-around: frame FE,03,01,02,03,06 -> Mem[FE]=01, Mem[FF]=02, then Mem[00]=03 overwritten by vector FE.
REQ-034 SHALL cover LEN=0: 256 bytes of value i, CSUM=80 -> all 256 writes, then vector; done=1.
REQ-035 SHALL cover backpressure and restart: random ld_valid gaps give identical results; ld_start mid-DATA is ignored; ld_start in DONE re-asserts cpu_rst=0.
REQ-036 SHALL cover reset mid-load: rst low during DATA -> all outputs at reset values within the same cycle; a subsequent full load succeeds.
